// File: rtl/meminstr_pkg.sv
//------------------------------------------------------------------------------
// meminstr_pkg: shared widths and master ids for the instruction-memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package meminstr_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 12;
  localparam int NUM_MASTERS = 2;

  typedef enum logic {
    MID_M0 = 1'b0,
    MID_M1 = 1'b1
  } mid_t;

endpackage

`default_nettype wire

// File: rtl/meminstr_rsp_slot.sv
//------------------------------------------------------------------------------
// meminstr_rsp_slot: per-master in-flight tracker and 1-entry response hold
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module meminstr_rsp_slot
  import meminstr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              slot_free
);

  logic              r_inflight;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_inflight <= issue;
      // Memory data is only valid for one cycle, so capture it if the master stalls
      if (r_inflight && !rsp_ready) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= mem_data;
      end else if (r_hold_valid && rsp_ready) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_hold_valid | r_inflight;
  assign rsp_data  = r_hold_valid ? r_hold_data : mem_data;
  assign slot_free = !(r_inflight | r_hold_valid) | rsp_ready;

endmodule

`default_nettype wire

// File: rtl/meminstr_arb.sv
//------------------------------------------------------------------------------
// meminstr_arb: round-robin two-port read arbiter for the 4096x12 instruction ROM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module meminstr_arb
  import meminstr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_valid,
  input  logic [ADDR_W-1:0] m0_req_addr,
  output logic              m0_req_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m0_rsp_ready,
  input  logic              m1_req_valid,
  input  logic [ADDR_W-1:0] m1_req_addr,
  output logic              m1_req_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  input  logic              m1_rsp_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  logic [NUM_MASTERS-1:0] w_req_valid;
  logic [NUM_MASTERS-1:0] w_rsp_ready;
  logic [NUM_MASTERS-1:0] w_slot_free;
  logic [NUM_MASTERS-1:0] w_eligible;
  logic [NUM_MASTERS-1:0] w_grant;
  logic [NUM_MASTERS-1:0] w_rsp_valid;
  logic [ADDR_W-1:0]      w_req_addr [NUM_MASTERS];
  logic [DATA_W-1:0]      w_rsp_data [NUM_MASTERS];

  mid_t              r_rr_last;
  logic [ADDR_W-1:0] r_last_addr;

  assign w_req_valid   = {m1_req_valid, m0_req_valid};
  assign w_rsp_ready   = {m1_rsp_ready, m0_rsp_ready};
  assign w_req_addr[0] = m0_req_addr;
  assign w_req_addr[1] = m1_req_addr;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slot
    meminstr_rsp_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .issue     (w_grant[i]),
      .mem_data  (mem_data),
      .rsp_ready (w_rsp_ready[i]),
      .rsp_valid (w_rsp_valid[i]),
      .rsp_data  (w_rsp_data[i]),
      .slot_free (w_slot_free[i])
    );
  end

  assign w_eligible = rst ? '0 : (w_req_valid & w_slot_free);

  // On a conflict the master that did not win last time goes first
  always_comb begin
    w_grant = w_eligible;
    if (&w_eligible) begin
      w_grant = (r_rr_last == MID_M1) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    mem_addr = r_last_addr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant[i]) mem_addr = w_req_addr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last   <= MID_M1;
      r_last_addr <= '0;
    end else if (|w_grant) begin
      r_rr_last   <= w_grant[1] ? MID_M1 : MID_M0;
      r_last_addr <= mem_addr;
    end
  end

  assign m0_req_ready = w_grant[0];
  assign m1_req_ready = w_grant[1];
  assign m0_rsp_valid = w_rsp_valid[0];
  assign m1_rsp_valid = w_rsp_valid[1];
  assign m0_rsp_data  = w_rsp_data[0];
  assign m1_rsp_data  = w_rsp_data[1];

endmodule

`default_nettype wire

// File: tb/tb_meminstr_arb.sv
//------------------------------------------------------------------------------
// tb_meminstr_arb: directed table, corner sequences and random traffic vs a queue model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_meminstr_arb;
  import meminstr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic              m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
  logic [ADDR_W-1:0] m0_req_addr, m1_req_addr, mem_addr;
  logic [DATA_W-1:0] m0_rsp_data, m1_rsp_data, mem_data;

  meminstr_arb dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_valid (m0_req_valid),
    .m0_req_addr  (m0_req_addr),
    .m0_req_ready (m0_req_ready),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_data  (m0_rsp_data),
    .m0_rsp_ready (m0_rsp_ready),
    .m1_req_valid (m1_req_valid),
    .m1_req_addr  (m1_req_addr),
    .m1_req_ready (m1_req_ready),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_data  (m1_rsp_data),
    .m1_rsp_ready (m1_rsp_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  // Synchronous ROM with 1-cycle read latency
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge clk) mem_data <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each master owns a queue of words it is owed, in order
  logic [DATA_W-1:0] q0[$], q1[$];
  logic              rr_m;
  logic [ADDR_W-1:0] last_m;
  logic              g0, g1, e_rv0, e_rv1;
  logic [ADDR_W-1:0] e_ma;
  logic [DATA_W-1:0] e_d0, e_d1;

  task automatic model_eval();
    logic el0, el1;
    el0 = !rst && m0_req_valid && (q0.size() == 0 || m0_rsp_ready);
    el1 = !rst && m1_req_valid && (q1.size() == 0 || m1_rsp_ready);
    g0  = el0 && (!el1 || rr_m);
    g1  = el1 && !g0;
    e_ma  = g0 ? m0_req_addr : (g1 ? m1_req_addr : last_m);
    e_rv0 = (q0.size() != 0);
    e_rv1 = (q1.size() != 0);
    e_d0  = e_rv0 ? q0[0] : '0;
    e_d1  = e_rv1 ? q1[0] : '0;
  endtask

  task automatic model_update();
    if (rst) begin
      q0.delete();
      q1.delete();
      rr_m   = 1'b1;
      last_m = '0;
    end else begin
      if (e_rv0 && m0_rsp_ready) void'(q0.pop_front());
      if (e_rv1 && m1_rsp_ready) void'(q1.pop_front());
      if (g0) begin q0.push_back(mem[m0_req_addr]); rr_m = 1'b0; last_m = m0_req_addr; end
      if (g1) begin q1.push_back(mem[m1_req_addr]); rr_m = 1'b1; last_m = m1_req_addr; end
    end
  endtask

  task automatic set_in(input logic v0, input logic [ADDR_W-1:0] a0, input logic r0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic r1);
    m0_req_valid = v0; m0_req_addr = a0; m0_rsp_ready = r0;
    m1_req_valid = v1; m1_req_addr = a1; m1_rsp_ready = r1;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge
  task automatic tick();
    #1;
    model_eval();
    chk("m0_req_ready", 32'(m0_req_ready), 32'(g0));
    chk("m1_req_ready", 32'(m1_req_ready), 32'(g1));
    chk("mem_addr", 32'(mem_addr), 32'(e_ma));
    if (!rst) begin
      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(e_rv0));
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(e_rv1));
      if (e_rv0) chk("m0_rsp_data", 32'(m0_rsp_data), 32'(e_d0));
      if (e_rv1) chk("m1_rsp_data", 32'(m1_rsp_data), 32'(e_d1));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic v0; logic [ADDR_W-1:0] a0; logic r0;
    logic v1; logic [ADDR_W-1:0] a1; logic r1;
    logic x_rdy0, x_rdy1, x_rv0, x_rv1;
    logic [DATA_W-1:0] x_d0, x_d1;
    logic [ADDR_W-1:0] x_ma;
  } vec_t;

  vec_t vecs[8];
  int   nresp;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);
    mem[12'h005] = 12'hABC;
    mem[12'h003] = 12'h5A5;
    mem[12'h010] = 12'h111;
    mem[12'h020] = 12'h222;

    // Alternating conflict from reset (m0 first), then a lone m0 read of 0x005
    vecs[0] = '{1, 12'h010, 1, 1, 12'h020, 1, 1, 0, 0, 0, 12'h000, 12'h000, 12'h010};
    vecs[1] = '{1, 12'h010, 1, 1, 12'h020, 1, 0, 1, 1, 0, 12'h111, 12'h000, 12'h020};
    vecs[2] = '{1, 12'h010, 1, 1, 12'h020, 1, 1, 0, 0, 1, 12'h000, 12'h222, 12'h010};
    vecs[3] = '{1, 12'h010, 1, 1, 12'h020, 1, 0, 1, 1, 0, 12'h111, 12'h000, 12'h020};
    vecs[4] = '{0, 12'h000, 1, 0, 12'h000, 1, 0, 0, 0, 1, 12'h000, 12'h222, 12'h020};
    vecs[5] = '{1, 12'h005, 1, 0, 12'h000, 1, 1, 0, 0, 0, 12'h000, 12'h000, 12'h005};
    vecs[6] = '{0, 12'h000, 1, 0, 12'h000, 1, 0, 0, 1, 0, 12'hABC, 12'h000, 12'h005};
    vecs[7] = '{0, 12'h000, 1, 0, 12'h000, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h005};

    rst = 1'b1;
    set_in(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset m0_rsp_valid", 32'(m0_rsp_valid), 0);
    chk("reset m1_rsp_valid", 32'(m1_rsp_valid), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].v0, vecs[i].a0, vecs[i].r0, vecs[i].v1, vecs[i].a1, vecs[i].r1);
      #1;
      chk("tbl m0_req_ready", 32'(m0_req_ready), 32'(vecs[i].x_rdy0));
      chk("tbl m1_req_ready", 32'(m1_req_ready), 32'(vecs[i].x_rdy1));
      chk("tbl m0_rsp_valid", 32'(m0_rsp_valid), 32'(vecs[i].x_rv0));
      chk("tbl m1_rsp_valid", 32'(m1_rsp_valid), 32'(vecs[i].x_rv1));
      if (vecs[i].x_rv0) chk("tbl m0_rsp_data", 32'(m0_rsp_data), 32'(vecs[i].x_d0));
      if (vecs[i].x_rv1) chk("tbl m1_rsp_data", 32'(m1_rsp_data), 32'(vecs[i].x_d1));
      chk("tbl mem_addr", 32'(mem_addr), 32'(vecs[i].x_ma));
      tick();
    end

    // m0 stalls on a held word while m1 streams five reads
    set_in(1, 12'h003, 1, 0, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 12'h003, 0, 1, ADDR_W'(12'h100 + k), 1);
      #1;
      chk("hold m0_rsp_valid", 32'(m0_rsp_valid), 1);
      chk("hold m0_rsp_data", 32'(m0_rsp_data), 32'h5A5);
      chk("hold m0_req_ready", 32'(m0_req_ready), 0);
      chk("stream m1_req_ready", 32'(m1_req_ready), 1);
      if (k > 0) chk("stream m1_rsp_data", 32'(m1_rsp_data), 32'(mem[12'h100 + k - 1]));
      tick();
    end
    set_in(0, 0, 1, 0, 0, 1);
    #1;
    chk("drain m0_rsp_data", 32'(m0_rsp_data), 32'h5A5);
    chk("stream last m1_rsp_data", 32'(m1_rsp_data), 32'(mem[12'h104]));
    tick();
    #1;
    chk("drained m0_rsp_valid", 32'(m0_rsp_valid), 0);

    // Lone m0 back-to-back reads of 0..7
    nresp = 0;
    for (int k = 0; k < 9; k++) begin
      set_in(k < 8, ADDR_W'(k), 1, 0, 0, 1);
      #1;
      if (k > 0) begin
        if (m0_rsp_valid) nresp++;
        chk("burst m0_rsp_data", 32'(m0_rsp_data), 32'(mem[k-1]));
      end
      tick();
    end
    chk("burst response count", 32'(nresp), 8);

    // Top-of-memory address and idle address hold
    set_in(0, 0, 1, 1, 12'hFFF, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, 0, 0, 1);
      #1;
      if (k == 0) chk("fff m1_rsp_data", 32'(m1_rsp_data), 32'(mem[4095]));
      chk("fff idle mem_addr", 32'(mem_addr), 32'hFFF);
      tick();
    end

    // Reset with m1 held and m0 in flight
    set_in(0, 0, 1, 1, 12'h030, 0);
    tick();
    set_in(1, 12'h040, 1, 0, 0, 0);
    tick();
    rst = 1'b1;
    set_in(1, 12'h041, 1, 1, 12'h031, 1);
    #1;
    chk("rst m0_req_ready", 32'(m0_req_ready), 0);
    chk("rst m1_req_ready", 32'(m1_req_ready), 0);
    tick();
    rst = 1'b0;
    set_in(1, 12'h050, 1, 1, 12'h060, 1);
    #1;
    chk("post-rst m0_rsp_valid", 32'(m0_rsp_valid), 0);
    chk("post-rst m1_rsp_valid", 32'(m1_rsp_valid), 0);
    chk("post-rst m0 first", 32'(m0_req_ready), 1);
    chk("post-rst m1 waits", 32'(m1_req_ready), 0);
    tick();

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in(1'($urandom), ADDR_W'($urandom), ($urandom_range(0, 3) != 0),
             1'($urandom), ADDR_W'($urandom), ($urandom_range(0, 3) != 0));
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meminstr_arb.md
Name: meminstr_arb

Overview:
Two-port read arbiter in front of the single-port, read-only 4096x12 instruction memory. It shares the memory between a fetch requester (m0) and a debug/trace requester (m1) using round-robin arbitration and valid/ready handshakes on both requests and responses. It tracks the memory's fixed 1-cycle read latency and routes each returned word to the requester that issued it. Each requester has a 1-entry response hold register so it can apply backpressure.

Parameters:
ADDR_W, 12, instruction memory address width (depth 2^ADDR_W)
DATA_W, 12, instruction word width

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
m0_req_valid  in  1  m0 read request valid
m0_req_addr  in  ADDR_W  m0 read address
m0_req_ready  out  1  m0 request accepted this cycle when valid&ready
m0_rsp_valid  out  1  m0 response word valid
m0_rsp_data  out  DATA_W  m0 response word
m0_rsp_ready  in  1  m0 consumes response when valid&ready
m1_req_valid, m1_req_addr, m1_req_ready, m1_rsp_valid, m1_rsp_data, m1_rsp_ready: same as m0, for m1
mem_addr  out  ADDR_W  address to instruction memory, sampled at posedge
mem_data  in  DATA_W  memory read data, valid the cycle after the address was sampled

Behaviour:
- Per master i, the state is inflight_i (a read was issued last cycle, so mem_data this cycle belongs to i) and hold_valid_i/hold_data_i.
- Response path:
  - rsp_valid_i = hold_valid_i | inflight_i.
  - rsp_data_i = hold_data_i if hold_valid_i, else mem_data.
  - inflight_i and hold_valid_i are never both 1.
  - If inflight_i is set and rsp_ready_i is 0, mem_data is captured into hold_data_i and hold_valid_i is set next cycle.
  - If hold_valid_i is set and rsp_ready_i is 1, hold_valid_i is cleared next cycle.
  - Held data stays stable until it is consumed.
- Eligibility: eligible_i = req_valid_i & (slot free by end of cycle), where slot free = !(inflight_i | hold_valid_i) | rsp_ready_i.
- Arbitration (combinational, rr_last register):
  - If only one master is eligible, it is granted.
  - If both are eligible, the master other than rr_last is granted.
  - rr_last updates to the granted id only on a grant.
  - Reset value of rr_last is 1, so m0 wins the first conflict.
- req_ready_i = grant_i. At most one grant per cycle.
- On a grant, mem_addr = granted address and inflight_i is set next cycle.
- With no grant, mem_addr = last_addr, a register holding the last issued address (reset 0). inflight_* is cleared next cycle.
- Latency: request accepted in cycle T, rsp_valid in T+1 with mem[addr]. Throughput is 1 read per cycle in aggregate, and 1 per cycle for a lone master with rsp_ready held at 1.
- Simultaneous events: a master may drain a response and be granted a new request in the same cycle. No response is ever dropped or reordered.
- Reset values: inflight_*=0, hold_valid_*=0, hold_data_*=0, rr_last=1, last_addr=0. Hence rsp_valid_*=0 and mem_addr=0 after reset.
- While rst=1, req_ready_* are forced to 0.
- Reset mid-operation: in-flight and held responses are discarded, and no rsp_valid appears in the cycle after reset deasserts.
- Addresses wrap naturally in ADDR_W bits. No range checking is done (0xFFF is legal).

Decomposition:
- Package meminstr_pkg: ADDR_W=12, DATA_W=12, master id type (MID_M0=0, MID_M1=1), NUM_MASTERS=2.
- Sub-module meminstr_rsp_slot, instantiated once per master. Inputs: clk, rst, issue, mem_data, rsp_ready. Outputs: rsp_valid, rsp_data, slot_free. It contains the inflight/hold logic.
- The top level contains only the arbiter, rr_last and the address mux/register.

Test Plan:
1. mem[0x005]=0xABC; m0 requests 0x005 with rsp_ready=1 -> m0_req_ready=1 in T, m0_rsp_valid=1 with data 0xABC in T+1 only, and m1_rsp_valid stays 0.
2. Both masters request every cycle (m0 at 0x010, m1 at 0x020), rsp_ready=1 -> grants go m0,m1,m0,m1…, each response arrives one cycle after its grant with the correct word, mem_addr alternates 0x010/0x020.
3. m0 reads 0x003 (0x5A5) and holds m0_rsp_ready=0 for 5 cycles while m1 streams 0x100..0x104 -> m0_rsp_data stays 0x5A5 throughout, m0_req_ready=0, m1 gets all 5 words in order; raising m0_rsp_ready drains m0 in 1 cycle.
4. m0 streams addresses 0..7 with rsp_ready=1 and m1 idle -> 8 responses in 8 consecutive cycles, data equal to mem[0..7].
5. m1 requests 0xFFF -> response equals mem[4095], and mem_addr holds 0xFFF on the following idle cycles.
6. Assert rst for 1 cycle while an m1 response is held and m0 is in flight -> req_ready=0 during rst, both rsp_valid=0 after reset, and on the next conflict m0 is granted first.
